// File: rtl/mmc1_serial_mapper.sv
// MMC1-family serial-load mapper for Famicom cartridges.
// A 5-bit serial shift port loads four internal registers: control, CHR bank 0,
// CHR bank 1 and PRG bank. Those registers drive the PRG, CHR and WRAM bank
// address lines and the nametable mirroring. Board options select the extra
// features: the consecutive-write filter, WRAM disable, SUROM outer PRG banking
// and SOROM/SXROM WRAM banking.
module mmc1_serial_mapper #(
  parameter bit IGNORE_CONSEC = 1'b1,
  parameter bit WRAM_DIS_EN   = 1'b1,
  parameter bit OUTER_PRG     = 1'b0,
  parameter bit WRAM_BANKING  = 1'b0
) (
  input  logic       CPU_M2,
  input  logic       nRESET,
  input  logic       CPU_A13,
  input  logic       CPU_A14,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  input  logic       PPU_A10,
  input  logic       PPU_A11,
  input  logic       PPU_A12,
  output logic       CIRAM_A10,
  output logic [4:0] PRG_A,
  output logic [4:0] CHR_A,
  output logic [1:0] WRAM_A,
  output logic       nPRG_CE,
  output logic       nWRAM_CE
);

  localparam logic [4:0] SHIFT_EMPTY  = 5'b10000;
  localparam logic [4:0] CONTROL_INIT = 5'b01100;

  logic [4:0] shift;
  logic [4:0] control;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;
  logic       wr_prev;

  logic       wr_evt;
  logic       wr_accept;
  logic [4:0] shift_next;
  logic [4:0] chr_act;
  logic       wram_en;

  // A write to $8000-$FFFF is a mapper write. The filter drops the second
  // write of a read-modify-write pair, because those writes land on back-to-back M2 cycles.
  assign wr_evt     = ~nCPU_ROMSEL & ~nCPU_RW;
  assign wr_accept  = wr_evt & ~(IGNORE_CONSEC & wr_prev);
  assign shift_next = {CPU_D0, shift[4:1]};

  // Serial port and register file, updated on the M2 falling edge.
  always_ff @(negedge CPU_M2 or negedge nRESET) begin
    if (!nRESET) begin
      shift   <= SHIFT_EMPTY;
      control <= CONTROL_INIT;
      chr0    <= 5'b00000;
      chr1    <= 5'b00000;
      prg     <= 5'b00000;
      wr_prev <= 1'b0;
    end else begin
      wr_prev <= wr_evt;
      if (wr_accept) begin
        if (CPU_D7) begin
          // Shift reset also forces PRG mode 3 (fixed last bank at $C000).
          shift   <= SHIFT_EMPTY;
          control <= control | CONTROL_INIT;
        end else if (!shift[0]) begin
          shift <= shift_next;
        end else begin
          // The marker bit reached bit 0, so this write supplies the fifth data bit.
          unique case ({CPU_A14, CPU_A13})
            2'b00:   control <= shift_next;
            2'b01:   chr0    <= shift_next;
            2'b10:   chr1    <= shift_next;
            default: prg     <= shift_next;
          endcase
          shift <= SHIFT_EMPTY;
        end
      end
    end
  end

  // Bank, mirroring and chip-enable decode, purely combinational from registers and live bus.
  always_comb begin
    chr_act   = (control[4] && PPU_A12) ? chr1 : chr0;
    wram_en   = WRAM_DIS_EN ? ~prg[4] : 1'b1;

    CIRAM_A10 = 1'b0;
    unique case (control[1:0])
      2'b00:   CIRAM_A10 = 1'b0;
      2'b01:   CIRAM_A10 = 1'b1;
      2'b10:   CIRAM_A10 = PPU_A10;
      default: CIRAM_A10 = PPU_A11;
    endcase

    PRG_A    = 5'b00000;
    PRG_A[4] = OUTER_PRG ? chr_act[4] : 1'b0;
    unique case (control[3:2])
      2'b00, 2'b01: PRG_A[3:0] = {prg[3:1], CPU_A14};
      2'b10:        PRG_A[3:0] = CPU_A14 ? prg[3:0] : 4'b0000;
      default:      PRG_A[3:0] = CPU_A14 ? 4'b1111  : prg[3:0];
    endcase

    CHR_A    = control[4] ? chr_act : {chr0[4:1], PPU_A12};
    WRAM_A   = WRAM_BANKING ? chr_act[3:2] : 2'b00;

    nPRG_CE  = nCPU_ROMSEL | ~nCPU_RW;
    nWRAM_CE = ~(CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & wram_en);
  end

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Directed bench for mmc1_serial_mapper. Two instances share the CPU/PPU bus:
// dut_a uses the default board options (filter on, no outer banking).
// dut_b has the filter off and both outer PRG and WRAM banking enabled.
module tb_mmc1_serial_mapper;

  logic CPU_M2 = 1'b0;
  logic nRESET, CPU_A13, CPU_A14, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7;
  logic PPU_A10, PPU_A11, PPU_A12;

  logic       a_ciram, b_ciram;
  logic [4:0] a_prg, b_prg, a_chr, b_chr;
  logic [1:0] a_wram, b_wram;
  logic       a_nprg, b_nprg, a_nwram, b_nwram;

  int total = 0;
  int bad   = 0;

  mmc1_serial_mapper #(
    .IGNORE_CONSEC(1'b1), .WRAM_DIS_EN(1'b1), .OUTER_PRG(1'b0), .WRAM_BANKING(1'b0)
  ) dut_a (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .PPU_A10(PPU_A10), .PPU_A11(PPU_A11), .PPU_A12(PPU_A12),
    .CIRAM_A10(a_ciram), .PRG_A(a_prg), .CHR_A(a_chr), .WRAM_A(a_wram),
    .nPRG_CE(a_nprg), .nWRAM_CE(a_nwram)
  );

  mmc1_serial_mapper #(
    .IGNORE_CONSEC(1'b0), .WRAM_DIS_EN(1'b1), .OUTER_PRG(1'b1), .WRAM_BANKING(1'b1)
  ) dut_b (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .PPU_A10(PPU_A10), .PPU_A11(PPU_A11), .PPU_A12(PPU_A12),
    .CIRAM_A10(b_ciram), .PRG_A(b_prg), .CHR_A(b_chr), .WRAM_A(b_wram),
    .nPRG_CE(b_nprg), .nWRAM_CE(b_nwram)
  );

  always #10 CPU_M2 = ~CPU_M2;

  // Drive one bus cycle; the DUT samples it on the next M2 falling edge.
  task automatic bus(input logic romsel, input logic rw, input logic a14, input logic a13,
                     input logic d0, input logic d7);
    nCPU_ROMSEL = romsel; nCPU_RW = rw; CPU_A14 = a14; CPU_A13 = a13;
    CPU_D0 = d0; CPU_D7 = d7;
    @(negedge CPU_M2); #1;
  endtask

  task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
    bus(1'b0, 1'b0, a14, a13, d0, d7);
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic swr(input logic a14, input logic a13, input logic d0, input logic d7);
    wr(a14, a13, d0, d7);
    idle();
  endtask

  task automatic load(input logic a14, input logic a13, input logic [4:0] v);
    for (int i = 0; i < 5; i++) swr(a14, a13, v[i], 1'b0);
  endtask

  // Put a ROM read on the bus, then let the combinational outputs settle.
  task automatic rom_read(input logic a14);
    nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b1; CPU_A14 = a14; CPU_A13 = 1'b0;
    CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    PPU_A10 = 1'b1; PPU_A11 = 1'b1; PPU_A12 = 1'b1;
    rom_read(1'b1);
    total++; if (a_prg !== 5'b01111) begin bad++; $display("FAIL reset_prg_c000_a got=%b exp=01111", a_prg); end
    total++; if (b_prg !== 5'b01111) begin bad++; $display("FAIL reset_prg_c000_b got=%b exp=01111", b_prg); end
    total++; if (a_nprg !== 1'b0) begin bad++; $display("FAIL reset_nprg_read got=%b exp=0", a_nprg); end
    rom_read(1'b0);
    total++; if (a_prg !== 5'b00000) begin bad++; $display("FAIL reset_prg_8000_a got=%b exp=00000", a_prg); end
    total++; if (a_ciram !== 1'b0) begin bad++; $display("FAIL reset_ciram got=%b exp=0", a_ciram); end
    total++; if (b_chr !== 5'b00001) begin bad++; $display("FAIL reset_chr got=%b exp=00001", b_chr); end
    total++; if (b_wram !== 2'b00) begin bad++; $display("FAIL reset_wram_a got=%b exp=00", b_wram); end
    idle();
  endtask

  task automatic test_prg_load();
    load(1'b1, 1'b1, 5'b00101);
    rom_read(1'b0);
    total++; if (a_prg !== 5'b00101) begin bad++; $display("FAIL prg_load_a got=%b exp=00101", a_prg); end
    total++; if (b_prg !== 5'b00101) begin bad++; $display("FAIL prg_load_b got=%b exp=00101", b_prg); end
    nCPU_RW = 1'b0; #1;
    total++; if (a_nprg !== 1'b1) begin bad++; $display("FAIL nprg_on_write got=%b exp=1", a_nprg); end
    idle();
  endtask

  task automatic test_consec_filter();
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) swr(1'b1, 1'b1, 1'b0, 1'b0);
    rom_read(1'b0);
    total++; if (b_prg !== 5'b00011) begin bad++; $display("FAIL rmw_nofilter_b got=%b exp=00011", b_prg); end
    total++; if (a_prg !== 5'b00101) begin bad++; $display("FAIL rmw_partial_a got=%b exp=00101", a_prg); end
    swr(1'b1, 1'b1, 1'b0, 1'b0);
    rom_read(1'b0);
    total++; if (a_prg !== 5'b00001) begin bad++; $display("FAIL rmw_filter_a got=%b exp=00001", a_prg); end
    total++; if (b_prg !== 5'b00011) begin bad++; $display("FAIL rmw_hold_b got=%b exp=00011", b_prg); end
    swr(1'b1, 1'b1, 1'b0, 1'b1);
    // D7 reset ignored by the filter in dut_a, honoured in dut_b
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    wr(1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    swr(1'b1, 1'b1, 1'b0, 1'b0);
    swr(1'b1, 1'b1, 1'b1, 1'b0);
    swr(1'b1, 1'b1, 1'b0, 1'b0);
    swr(1'b1, 1'b1, 1'b0, 1'b0);
    rom_read(1'b0);
    total++; if (a_prg !== 5'b00101) begin bad++; $display("FAIL ignored_d7_a got=%b exp=00101", a_prg); end
    total++; if (b_prg !== 5'b00011) begin bad++; $display("FAIL honoured_d7_b got=%b exp=00011", b_prg); end
    swr(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_chr_mirror();
    load(1'b0, 1'b0, 5'b10010);
    load(1'b0, 1'b1, 5'b00011);
    load(1'b1, 1'b0, 5'b01100);
    PPU_A12 = 1'b0; PPU_A10 = 1'b0;
    rom_read(1'b1);
    total++; if (a_chr !== 5'b00011) begin bad++; $display("FAIL chr_a12lo got=%b exp=00011", a_chr); end
    total++; if (a_ciram !== 1'b0) begin bad++; $display("FAIL mirror_a10lo got=%b exp=0", a_ciram); end
    total++; if (b_wram !== 2'b00) begin bad++; $display("FAIL wram_chr0 got=%b exp=00", b_wram); end
    total++; if (a_prg !== 5'b00101) begin bad++; $display("FAIL prg32k_hi_a got=%b exp=00101", a_prg); end
    total++; if (b_prg !== 5'b00011) begin bad++; $display("FAIL prg32k_hi_b got=%b exp=00011", b_prg); end
    PPU_A12 = 1'b1; PPU_A10 = 1'b1;
    rom_read(1'b0);
    total++; if (b_chr !== 5'b01100) begin bad++; $display("FAIL chr_a12hi got=%b exp=01100", b_chr); end
    total++; if (b_ciram !== 1'b1) begin bad++; $display("FAIL mirror_a10hi got=%b exp=1", b_ciram); end
    total++; if (b_wram !== 2'b11) begin bad++; $display("FAIL wram_chr1 got=%b exp=11", b_wram); end
    total++; if (a_wram !== 2'b00) begin bad++; $display("FAIL wram_nobank got=%b exp=00", a_wram); end
    total++; if (a_prg !== 5'b00100) begin bad++; $display("FAIL prg32k_lo_a got=%b exp=00100", a_prg); end
    idle();
  endtask

  task automatic test_shift_reset();
    for (int i = 0; i < 3; i++) swr(1'b1, 1'b1, 1'b1, 1'b0);
    swr(1'b1, 1'b1, 1'b0, 1'b1);
    rom_read(1'b1);
    total++; if (a_prg !== 5'b01111) begin bad++; $display("FAIL d7_mode3 got=%b exp=01111", a_prg); end
    load(1'b1, 1'b1, 5'b01010);
    rom_read(1'b0);
    total++; if (a_prg !== 5'b01010) begin bad++; $display("FAIL reload_a got=%b exp=01010", a_prg); end
    total++; if (b_prg !== 5'b01010) begin bad++; $display("FAIL reload_b got=%b exp=01010", b_prg); end
    idle();
  endtask

  task automatic test_outer_wram();
    load(1'b0, 1'b0, 5'b01101);
    load(1'b0, 1'b1, 5'b11000);
    load(1'b1, 1'b1, 5'b10000);
    PPU_A12 = 1'b0;
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_A14 = 1'b1; CPU_A13 = 1'b1;
    @(posedge CPU_M2); #1;
    total++; if (b_prg !== 5'b11111) begin bad++; $display("FAIL outer_prg_b got=%b exp=11111", b_prg); end
    total++; if (a_prg !== 5'b01111) begin bad++; $display("FAIL no_outer_a got=%b exp=01111", a_prg); end
    total++; if (b_wram !== 2'b10) begin bad++; $display("FAIL wram_bank got=%b exp=10", b_wram); end
    total++; if (b_nwram !== 1'b1) begin bad++; $display("FAIL wram_disabled got=%b exp=1", b_nwram); end
    total++; if (a_ciram !== 1'b1) begin bad++; $display("FAIL mirror_one got=%b exp=1", a_ciram); end
    total++; if (a_chr !== 5'b11000) begin bad++; $display("FAIL chr8k got=%b exp=11000", a_chr); end
    total++; if (a_nprg !== 1'b1) begin bad++; $display("FAIL nprg_wram got=%b exp=1", a_nprg); end
    load(1'b1, 1'b1, 5'b00000);
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_A14 = 1'b1; CPU_A13 = 1'b1;
    @(posedge CPU_M2); #1;
    total++; if (a_nwram !== 1'b0) begin bad++; $display("FAIL wram_en_a got=%b exp=0", a_nwram); end
    total++; if (b_nwram !== 1'b0) begin bad++; $display("FAIL wram_en_b got=%b exp=0", b_nwram); end
    @(negedge CPU_M2); #1;
    total++; if (a_nwram !== 1'b1) begin bad++; $display("FAIL wram_m2low got=%b exp=1", a_nwram); end
    CPU_A13 = 1'b0;
    @(posedge CPU_M2); #1;
    total++; if (a_nwram !== 1'b1) begin bad++; $display("FAIL wram_a13lo got=%b exp=1", a_nwram); end
    idle();
  endtask

  task automatic test_async_reset();
    swr(1'b1, 1'b1, 1'b1, 1'b0);
    swr(1'b1, 1'b1, 1'b1, 1'b0);
    nRESET = 1'b0;
    PPU_A12 = 1'b1;
    rom_read(1'b0);
    total++; if (b_prg !== 5'b00000) begin bad++; $display("FAIL areset_prg_lo got=%b exp=00000", b_prg); end
    total++; if (b_chr !== 5'b00001) begin bad++; $display("FAIL areset_chr got=%b exp=00001", b_chr); end
    total++; if (b_wram !== 2'b00) begin bad++; $display("FAIL areset_wram got=%b exp=00", b_wram); end
    total++; if (a_ciram !== 1'b0) begin bad++; $display("FAIL areset_ciram got=%b exp=0", a_ciram); end
    rom_read(1'b1);
    total++; if (b_prg !== 5'b01111) begin bad++; $display("FAIL areset_prg_hi got=%b exp=01111", b_prg); end
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_A14 = 1'b1; CPU_A13 = 1'b1;
    @(posedge CPU_M2); #1;
    total++; if (b_nwram !== 1'b0) begin bad++; $display("FAIL areset_wram_ce got=%b exp=0", b_nwram); end
    nRESET = 1'b1;
    load(1'b1, 1'b1, 5'b00110);
    rom_read(1'b0);
    total++; if (a_prg !== 5'b00110) begin bad++; $display("FAIL post_reset_load_a got=%b exp=00110", a_prg); end
    total++; if (b_prg !== 5'b00110) begin bad++; $display("FAIL post_reset_load_b got=%b exp=00110", b_prg); end
    idle();
  endtask

  initial begin
    nRESET = 1'b0;
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_A14 = 1'b0; CPU_A13 = 1'b0;
    CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    PPU_A10 = 1'b0; PPU_A11 = 1'b0; PPU_A12 = 1'b0;
    #25 nRESET = 1'b1;
    @(negedge CPU_M2); #1;
    test_reset();
    test_prg_load();
    test_consec_filter();
    test_chr_mirror();
    test_shift_reset();
    test_outer_wram();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmc1_serial_mapper.md
# mmc1_serial_mapper

Parametrised MMC1-family serial-load mapper for Famicom cartridges: a 5-bit serial shift port feeds four internal registers (control, CHR bank 0, CHR bank 1, PRG bank), which drive PRG/CHR/WRAM address lines and nametable mirroring. It extends the base MMC1 with a consecutive-write filter, a PRG-RAM disable bit, SUROM-style outer 256 KB PRG banking and SOROM/SXROM-style WRAM banking, each selectable per board by parameter. It sits between the cartridge edge connector and the PRG ROM, CHR ROM/RAM, WRAM and CIRAM.

## Interface
- IGNORE_CONSEC, 1: 1 = ignore a mapper write on the M2 cycle directly after another mapper write
- WRAM_DIS_EN, 1: 1 = PRG register bit 4 disables WRAM (MMC1B behaviour); 0 = WRAM always enabled
- OUTER_PRG, 0: 1 = active CHR register bit 4 drives PRG_A[4] (PRG A18, SUROM)
- WRAM_BANKING, 0: 1 = active CHR register bits 3:2 drive WRAM_A[1:0] (WRAM A14:A13, SOROM/SXROM)
- CPU_M2  in  1  clock; all state updates on the falling edge
- nRESET  in  1  asynchronous active-low reset
- CPU_A13, CPU_A14  in  1 each  CPU address
- nCPU_ROMSEL  in  1  low = $8000-$FFFF access while M2 is high
- nCPU_RW  in  1  low = CPU write
- CPU_D0, CPU_D7  in  1 each  serial data bit / shift reset bit
- PPU_A10, PPU_A11, PPU_A12  in  1 each  PPU address
- CIRAM_A10  out  1  nametable select
- PRG_A  out  5  PRG ROM A18..A14
- CHR_A  out  5  CHR A16..A12
- WRAM_A  out  2  WRAM A14..A13
- nPRG_CE  out  1  PRG ROM chip enable, active low
- nWRAM_CE  out  1  WRAM chip enable, active low

## Operation
- Registers: shift[4:0], control[4:0], chr0[4:0], chr1[4:0], prg[4:0], flag wr_prev.
- Reset: shift=5'b10000, control=5'b01100, chr0=chr1=prg=0, wr_prev=0.
- Write event: nCPU_ROMSEL=0 and nCPU_RW=0 sampled at the falling edge of CPU_M2. Any other cycle clears wr_prev.
- Filter: with IGNORE_CONSEC=1, a write event while wr_prev=1 changes no register. Every write event, accepted or ignored, sets wr_prev=1.
- Accepted write, D7=1: shift=5'b10000; control=control | 5'b01100. Other registers are unchanged.
- Accepted write, D7=0, shift[0]=0: shift={D0, shift[4:1]}.
- Accepted write, D7=0, shift[0]=1 (fifth bit): value={D0, shift[4:1]}. {A14,A13} selects the target: 00 control, 01 chr0, 10 chr1, 11 prg. Then shift=5'b10000.
- Active CHR register (chrA): chr1 if control[4]=1 and PPU_A12=1, otherwise chr0.
- Mirroring, control[1:0]: 00 gives CIRAM_A10=0, 01 gives 1, 10 gives PPU_A10, 11 gives PPU_A11.
- PRG_A[4]: chrA[4] if OUTER_PRG=1, else 0.
- PRG_A[3:0] by control[3:2]:
  - 0x: {prg[3:1], CPU_A14}
  - 10: A14=0 gives 0000, A14=1 gives prg[3:0]
  - 11: A14=0 gives prg[3:0], A14=1 gives 1111
- CHR_A:
  - control[4]=1: chrA[4:0]
  - control[4]=0: {chr0[4:1], PPU_A12}
- WRAM_A: chrA[3:2] if WRAM_BANKING=1, else 00.
- nPRG_CE = nCPU_ROMSEL | ~nCPU_RW. ROM is never enabled on a mapper write.
- nWRAM_CE = ~(CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & en). This decodes $6000-$7FFF.
  - en = ~prg[4] if WRAM_DIS_EN=1, else 1.

## Timing
- Register updates land on the CPU_M2 falling edge of the write cycle and are visible on the outputs in the following cycle.
- All address, mirroring and chip-enable outputs are combinational from registers and live inputs. They add zero latency.
- A full register load takes 5 accepted writes on 5 distinct non-consecutive cycles.
- Reset asserted mid-sequence discards the partial shift immediately and asynchronously. Outputs revert to reset-derived values:
  - CIRAM_A10=0
  - PRG_A: 00000 when A14=0, 01111 when A14=1
  - CHR_A: {0000, PPU_A12}
  - WRAM_A=00
  - WRAM enabled
- A D7=1 write that the filter ignores has no effect.
- Non-mapper cycles between the 5 writes do not disturb the shift register.

## Test plan
- Reset, read $C000 (A14=1) -> PRG_A=01111. Read $8000 -> PRG_A=00000. CIRAM_A10=0.
- 5 spaced writes to $E000 with D0 bits 1,0,1,0,0 -> prg=00101. With control=01100, A14=0 gives PRG_A=00101.
- Write $8000 D7=0 with D0=1, then an immediate second write D7=0 with D0=1 (RMW pattern) -> with IGNORE_CONSEC=1, only one bit shifts (shift=11000). With IGNORE_CONSEC=0, both bits shift.
- Load control=10010, chr0=00011, chr1=01100 -> PPU_A12=0 gives CHR_A=00011; PPU_A12=1 gives 01100; CIRAM_A10 follows PPU_A10.
- After 3 serial bits, write D7=1 -> shift=10000, control[3:2]=11. The next 5 writes load cleanly.
- OUTER_PRG=1, WRAM_BANKING=1, chr0=11000, prg=10000, access $6000 with M2 high -> PRG_A[4]=1, WRAM_A=10, nWRAM_CE=1. After clearing prg[4], nWRAM_CE=0.
